// File: rtl/cordic_arbiter.sv
// Purpose : shares one fixed-latency cordic sin/cos pipeline among NUM_REQ round-robin requesters.
// Latency : request accepted in cycle t -> response at the FIFO head in cycle t+LATENCY+1.
// Backpr. : credits stop new grants before the response FIFO could overflow; the cordic never stalls.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset (also resets the attached cordic)
//   req_valid/req_theta/req_ready   per-requester angle handshake; req_ready is one-hot-or-zero
//   resp_valid/resp_ready/resp_id/resp_cos/resp_sin   response FIFO head, valid/ready
//   cor_valid_in/cor_theta_in  drive the cordic input
//   cor_valid_out/cor_cos_out/cor_sin_out   cordic results
//   busy                       results outstanding (in flight or buffered)
//   tag_err                    sticky: cordic output valid disagreed with the ID tag pipeline

// Small generic synchronous FIFO, first-word fall-through.
// Latency : a write appears on rd_* the cycle after it is written.
// Backpr. : no write-side ready; the producer must guarantee it never writes into a full FIFO
//           unless it pops in the same cycle.
module cordic_arb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             pop;

  assign pop    = rd_vld && rd_rdy;
  assign rd_vld = (count != '0);
  assign rd_dat = mem[rd_ptr];

  // Storage carries no reset: contents are only observed while count != 0.
  always_ff @(posedge clk) begin
    if (wr_vld) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_vld) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      end
      // When full, a write and a pop together hit the same slot: the head is
      // read before the edge and overwritten at it, so no data is lost.
      case ({wr_vld, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module cordic_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int LATENCY    = 16,
  parameter int RESP_DEPTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*32-1:0]   req_theta,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [15:0]             resp_cos,
  output logic [15:0]             resp_sin,
  output logic                    cor_valid_in,
  output logic [31:0]             cor_theta_in,
  input  logic                    cor_valid_out,
  input  logic [15:0]             cor_cos_out,
  input  logic [15:0]             cor_sin_out,
  output logic                    busy,
  output logic                    tag_err
);
  localparam int CRED_W = $clog2(RESP_DEPTH + 1);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [15:0]     cos_v;
    logic [15:0]     sin_v;
  } resp_ent_t;

  logic [ID_W-1:0]   rr_ptr;
  logic [CRED_W-1:0] credits;
  logic              can_issue;
  logic              grant_any;
  logic [ID_W-1:0]   grant_id;
  logic [NUM_REQ-1:0] grant;
  logic              resp_pop;

  logic [LATENCY-1:0] tag_vld;
  logic [ID_W-1:0]    tag_id [LATENCY];
  logic               cap_vld;
  resp_ent_t          cap_dat;
  resp_ent_t          head_dat;

  // Every result still owed to the FIFO (in flight or buffered) holds a credit,
  // so a grant is only given while a FIFO slot is guaranteed for its result.
  // Grants are held off during reset since the cordic is being cleared too.
  assign can_issue = !reset && (credits < CRED_W'(RESP_DEPTH));
  assign resp_pop  = resp_valid && resp_ready;
  assign busy      = (credits != '0);

  // Round-robin: first search rr_ptr..NUM_REQ-1, then wrap to 0..rr_ptr-1.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (can_issue && !grant_any && req_valid[i] && (ID_W'(i) >= rr_ptr)) begin
        grant[i]  = 1'b1;
        grant_id  = ID_W'(i);
        grant_any = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (can_issue && !grant_any && req_valid[i] && (ID_W'(i) < rr_ptr)) begin
        grant[i]  = 1'b1;
        grant_id  = ID_W'(i);
        grant_any = 1'b1;
      end
    end
  end

  always_comb begin
    cor_theta_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        cor_theta_in = req_theta[32*i +: 32];
      end
    end
  end

  assign req_ready    = grant;
  assign cor_valid_in = grant_any;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credits <= '0;
    end else begin
      case ({cor_valid_in, resp_pop})
        2'b10:   credits <= credits + CRED_W'(1);
        2'b01:   credits <= credits - CRED_W'(1);
        default: credits <= credits;
      endcase
    end
  end

  // Tag pipeline mirrors the cordic depth: the last stage lines up with cor_valid_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_vld <= '0;
    end else begin
      tag_vld <= {tag_vld[LATENCY-2:0], cor_valid_in};
    end
  end

  always_ff @(posedge clk) begin
    tag_id[0] <= grant_id;
    for (int s = 1; s < LATENCY; s++) begin
      tag_id[s] <= tag_id[s-1];
    end
  end

  // A valid mismatch means the tag alignment can no longer be trusted; flag it
  // and drop that cycle's result rather than pushing a mislabelled entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_err <= 1'b0;
    end else if (cor_valid_out != tag_vld[LATENCY-1]) begin
      tag_err <= 1'b1;
    end
  end

  assign cap_vld       = cor_valid_out && tag_vld[LATENCY-1];
  assign cap_dat.id    = tag_id[LATENCY-1];
  assign cap_dat.cos_v = cor_cos_out;
  assign cap_dat.sin_v = cor_sin_out;

  cordic_arb_fifo #(
    .WIDTH ($bits(resp_ent_t)),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (cap_vld),
    .wr_dat (cap_dat),
    .rd_vld (resp_valid),
    .rd_rdy (resp_ready),
    .rd_dat (head_dat)
  );

  assign resp_id  = head_dat.id;
  assign resp_cos = head_dat.cos_v;
  assign resp_sin = head_dat.sin_v;
endmodule

// File: tb/tb_cordic_arbiter.sv
module tb_cordic_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int ID_W       = 2;
  localparam int LATENCY    = 16;
  localparam int RESP_DEPTH = 32;

  // Requester angles; the stand-in cordic below returns cos = theta[31:16]^7FFF,
  // sin = theta[15:0], so the expected results are written out by hand.
  localparam logic [31:0] TH      [4] = '{32'h1111_0AAA, 32'h2222_0BBB, 32'h3333_0CCC, 32'h4444_0DDD};
  localparam logic [15:0] EXP_COS [4] = '{16'h6EEE, 16'h5DDD, 16'h4CCC, 16'h3BBB};
  localparam logic [15:0] EXP_SIN [4] = '{16'h0AAA, 16'h0BBB, 16'h0CCC, 16'h0DDD};

  logic                  clk;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_theta;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [15:0]           resp_cos;
  logic [15:0]           resp_sin;
  logic                  cor_valid_in;
  logic [31:0]           cor_theta_in;
  logic                  cor_valid_out;
  logic [15:0]           cor_cos_out;
  logic [15:0]           cor_sin_out;
  logic                  busy;
  logic                  tag_err;
  logic                  inj;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  cordic_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .LATENCY(LATENCY), .RESP_DEPTH(RESP_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_theta(req_theta), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_cos(resp_cos), .resp_sin(resp_sin),
    .cor_valid_in(cor_valid_in), .cor_theta_in(cor_theta_in),
    .cor_valid_out(cor_valid_out), .cor_cos_out(cor_cos_out), .cor_sin_out(cor_sin_out),
    .busy(busy), .tag_err(tag_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Stand-in cordic: fixed LATENCY delay line with a trivial transfer function.
  logic [LATENCY-1:0] m_vld;
  logic [31:0]        m_th [LATENCY];
  always @(posedge clk) begin
    if (reset) m_vld <= '0;
    else       m_vld <= {m_vld[LATENCY-2:0], cor_valid_in};
    m_th[0] <= cor_theta_in;
    for (int s = 1; s < LATENCY; s++) m_th[s] <= m_th[s-1];
  end
  assign cor_valid_out = m_vld[LATENCY-1] | inj;
  assign cor_cos_out   = m_th[LATENCY-1][31:16] ^ 16'h7FFF;
  assign cor_sin_out   = m_th[LATENCY-1][15:0];

  // Record every accepted response together with the cycle it was popped in.
  typedef struct {
    int              c;
    logic [ID_W-1:0] id;
    logic [15:0]     cs;
    logic [15:0]     sn;
  } rsp_t;
  rsp_t q[$];
  always @(negedge clk) begin
    if (!reset && resp_valid && resp_ready) q.push_back('{cyc, resp_id, resp_cos, resp_sin});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Inputs change 2 time units after the edge; outputs are sampled 4 after.
  task automatic next_cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    next_cyc();
    reset      = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b0;
    inj        = 1'b0;
    next_cyc();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t0, c0, w, ngrant, nstale;
    int fair_exp [8];
    fair_exp = '{1, 3, 1, 3, 1, 3, 0, 1};

    reset      = 1'b1;
    req_valid  = '0;
    req_theta  = {TH[3], TH[2], TH[1], TH[0]};
    resp_ready = 1'b0;
    inj        = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) next_cyc();
    req_valid = 4'hF;
    settle();
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_cor_valid_in", 32'(cor_valid_in), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_tag_err", 32'(tag_err), 32'h0);
    req_valid = '0;
    next_cyc();
    reset = 1'b0;
    settle();
    chk("post_rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("post_rst_busy", 32'(busy), 32'h0);

    // ---------------- single request, theta = 0 ----------------
    req_theta = {TH[3], TH[2], TH[1], 32'h0};
    req_valid = 4'b0001;
    settle();
    chk("single_ready", 32'(req_ready), 32'h1);
    chk("single_theta", cor_theta_in, 32'h0);
    t0 = cyc;
    next_cyc();
    req_valid = '0;
    req_theta = {TH[3], TH[2], TH[1], TH[0]};
    settle();
    w = 0;
    while (!resp_valid && w < 40) begin
      next_cyc();
      settle();
      w++;
    end
    chk("single_resp_valid", 32'(resp_valid), 32'h1);
    chk("single_latency", 32'(cyc - t0), 32'd17);
    chk("single_id", 32'(resp_id), 32'h0);
    chk("single_cos", 32'(resp_cos), 32'h7FFF);
    chk("single_sin", 32'(resp_sin), 32'h0000);
    chk("single_busy_held", 32'(busy), 32'h1);
    resp_ready = 1'b1;
    next_cyc();
    resp_ready = 1'b0;
    settle();
    chk("single_busy_after_pop", 32'(busy), 32'h0);
    chk("single_empty_after_pop", 32'(resp_valid), 32'h0);

    // ---------------- round robin, all requesters, resp_ready = 1 ----------------
    do_reset();
    q.delete();
    resp_ready = 1'b1;
    req_valid  = 4'hF;
    c0 = 0;
    for (int k = 0; k < 12; k++) begin
      settle();
      if (k == 0) c0 = cyc;
      chk("rr_grant", 32'(req_ready), 32'(1) << (k % 4));
      chk("rr_theta", cor_theta_in, TH[k % 4]);
      next_cyc();
    end
    req_valid = '0;
    repeat (25) next_cyc();
    chk("rr_resp_count", 32'(q.size()), 32'd12);
    for (int j = 0; j < 12 && j < q.size(); j++) begin
      chk("rr_resp_id", 32'(q[j].id), 32'(j % 4));
      chk("rr_resp_cycle", 32'(q[j].c), 32'(c0 + 17 + j));
      chk("rr_resp_cos", 32'(q[j].cs), 32'(EXP_COS[j % 4]));
      chk("rr_resp_sin", 32'(q[j].sn), 32'(EXP_SIN[j % 4]));
    end

    // ---------------- fairness ----------------
    do_reset();
    q.delete();
    resp_ready = 1'b1;
    req_valid  = 4'b1010;
    for (int k = 0; k < 8; k++) begin
      if (k == 5) req_valid = 4'b1011;
      settle();
      chk("fair_grant", 32'(req_ready), 32'(1) << fair_exp[k]);
      next_cyc();
    end
    req_valid = '0;
    repeat (25) next_cyc();
    chk("fair_resp_count", 32'(q.size()), 32'd8);
    for (int j = 0; j < 8 && j < q.size(); j++) begin
      chk("fair_resp_id", 32'(q[j].id), 32'(fair_exp[j]));
    end

    // ---------------- backpressure / credits ----------------
    do_reset();
    q.delete();
    resp_ready = 1'b0;
    req_valid  = 4'hF;
    ngrant = 0;
    repeat (40) begin
      settle();
      if (req_ready != '0) ngrant++;
      next_cyc();
    end
    chk("bp_grant_count", 32'(ngrant), 32'd32);
    settle();
    chk("bp_blocked", 32'(req_ready), 32'h0);
    repeat (20) next_cyc();
    settle();
    chk("bp_tag_err", 32'(tag_err), 32'h0);
    chk("bp_resp_valid", 32'(resp_valid), 32'h1);
    chk("bp_head_id", 32'(resp_id), 32'h0);
    chk("bp_head_cos", 32'(resp_cos), 32'(EXP_COS[0]));
    chk("bp_busy", 32'(busy), 32'h1);
    resp_ready = 1'b1;
    settle();
    chk("bp_pop_cycle_ready", 32'(req_ready), 32'h0);
    next_cyc();
    resp_ready = 1'b0;
    settle();
    chk("bp_one_grant", 32'(req_ready), 32'h1);
    chk("bp_next_head_id", 32'(resp_id), 32'h1);
    next_cyc();
    settle();
    chk("bp_blocked_again", 32'(req_ready), 32'h0);
    req_valid  = '0;
    resp_ready = 1'b1;
    repeat (60) next_cyc();
    resp_ready = 1'b0;
    settle();
    chk("bp_drain_count", 32'(q.size()), 32'd33);
    for (int j = 0; j < 33 && j < q.size(); j++) begin
      chk("bp_drain_id", 32'(q[j].id), 32'(j % 4));
    end
    chk("bp_idle_busy", 32'(busy), 32'h0);
    chk("bp_final_tag_err", 32'(tag_err), 32'h0);

    // ---------------- reset mid-stream: 10 in flight, 5 buffered ----------------
    do_reset();
    q.delete();
    resp_ready = 1'b0;
    req_valid  = 4'hF;
    repeat (15) next_cyc();
    req_valid = '0;
    repeat (6) next_cyc();
    settle();
    chk("mid_pre_resp_valid", 32'(resp_valid), 32'h1);
    chk("mid_pre_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    next_cyc();
    reset = 1'b0;
    settle();
    chk("mid_resp_valid", 32'(resp_valid), 32'h0);
    chk("mid_busy", 32'(busy), 32'h0);
    req_valid = 4'hF;
    settle();
    chk("mid_rr_ptr_zero", 32'(req_ready), 32'h1);
    req_valid  = '0;
    resp_ready = 1'b1;
    nstale = 0;
    repeat (20) begin
      next_cyc();
      settle();
      if (resp_valid) nstale++;
    end
    chk("mid_no_stale", 32'(nstale), 32'h0);
    chk("mid_no_stale_pops", 32'(q.size()), 32'h0);
    chk("mid_tag_err", 32'(tag_err), 32'h0);

    // ---------------- fault injection ----------------
    resp_ready = 1'b0;
    req_valid  = 4'b0011;
    next_cyc();
    next_cyc();
    req_valid = '0;
    repeat (20) next_cyc();
    q.delete();
    inj = 1'b1;
    next_cyc();
    inj = 1'b0;
    settle();
    chk("inj_tag_err", 32'(tag_err), 32'h1);
    repeat (5) next_cyc();
    settle();
    chk("inj_tag_err_sticky", 32'(tag_err), 32'h1);
    resp_ready = 1'b1;
    repeat (10) next_cyc();
    resp_ready = 1'b0;
    settle();
    chk("inj_occupancy", 32'(q.size()), 32'd2);
    if (q.size() >= 2) begin
      chk("inj_id0", 32'(q[0].id), 32'h0);
      chk("inj_id1", 32'(q[1].id), 32'h1);
    end
    chk("inj_busy", 32'(busy), 32'h0);
    chk("inj_tag_err_still", 32'(tag_err), 32'h1);
    do_reset();
    settle();
    chk("inj_tag_err_cleared", 32'(tag_err), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cordic_arbiter.md
Name: cordic_arbiter

Overview:
- Shares one 16-stage `cordic` sin/cos pipeline among NUM_REQ requesters.
- Round-robin arbitration; accepts at most one request per cycle into the pipeline.
- Tags each issued angle with its requester ID in a shift register aligned to the pipeline latency.
- Collects results into a response FIFO with valid/ready backpressure. A credit counter guarantees the FIFO can never overflow, because the `cordic` itself has no stall.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID; must be >= clog2(NUM_REQ).
- LATENCY, 16, cycles from `cor_valid_in` to `cor_valid_out` of the attached `cordic`.
- RESP_DEPTH, 32, response FIFO entries; also the max outstanding credit count (must be >= LATENCY+1 for full throughput).

Ports:
- clk  in  1  clock, all state rising-edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_theta  in  NUM_REQ*32  per-requester angle; slice i is bits [32*i+31:32*i], same format as `cordic` `theta_in`.
- req_ready  out  NUM_REQ  one-hot-or-zero grant; handshake when req_valid[i] && req_ready[i].
- resp_valid  out  1  response FIFO head valid.
- resp_ready  in  1  consumer accepts head.
- resp_id  out  ID_W  requester ID of head.
- resp_cos  out  16  cos result of head.
- resp_sin  out  16  sin result of head.
- cor_valid_in  out  1  to `cordic` valid_in.
- cor_theta_in  out  32  to `cordic` theta_in.
- cor_valid_out  in  1  from `cordic` valid_out.
- cor_cos_out  in  16  from `cordic` cos_out.
- cor_sin_out  in  16  from `cordic` sin_out.
- busy  out  1  credits outstanding != 0.
- tag_err  out  1  sticky: `cordic` output/tag valid mismatch.

Behaviour:
- Reset:
  - rr_ptr=0, credits=0, tag pipeline valids=0, FIFO empty, tag_err=0.
  - Outputs during/after reset: req_ready=0, resp_valid=0, busy=0, cor_valid_in=0.
  - resp_id/cos/sin are don't-care when resp_valid=0.
  - The same reset drives the `cordic`, so reset mid-operation discards every in-flight and buffered result; no response is emitted for them.
- Credit rule:
  - can_issue = (credits < RESP_DEPTH).
  - credits increments on issue and decrements on FIFO pop (resp_valid && resp_ready).
  - Issue and pop in the same cycle leave credits unchanged.
  - credits covers both in-flight and buffered results, so the FIFO never overflows.
- Arbitration (combinational, same cycle):
  - If can_issue, grant the first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready = one-hot of the grant; req_ready=0 for all if !can_issue or no request is valid.
  - req_ready[i] may depend on req_valid; requesters must not make req_valid depend on req_ready.
- Issue:
  - cor_valid_in = |grant.
  - cor_theta_in = granted slice when cor_valid_in=1, else 0.
  - On a grant to i, rr_ptr <= (i+1) mod NUM_REQ at the clock edge; with no grant, rr_ptr holds.
- Tag pipeline:
  - LATENCY-deep shift register of {valid, id}.
  - Stage 0 is loaded with {cor_valid_in, granted id} each cycle.
  - Its output is aligned with cor_valid_out.
- Result capture:
  - When cor_valid_out=1 and tag valid=1, write {tag id, cor_cos_out, cor_sin_out} into the FIFO.
  - Any mismatch (cor_valid_out != tag valid) sets tag_err=1 until reset, and nothing is written that cycle.
- FIFO:
  - Synchronous, first-word fall-through, registered head.
  - A write to an empty FIFO appears on resp_* the next cycle.
  - Simultaneous write and pop is legal at any occupancy, including full, which credits prevent from overflowing.
  - resp_* hold stable while resp_valid && !resp_ready.
- Latency:
  - A request accepted in cycle t gives cor_valid_out in cycle t+LATENCY.
  - Earliest resp_valid is cycle t+LATENCY+1.
- Throughput: 1 request/cycle sustained when resp_ready=1 and RESP_DEPTH >= LATENCY+1.
- Ordering: responses leave in issue order; there is no per-requester reordering.
- busy = (credits != 0).

Test Plan:
- Single request: req_valid=4'b0001, theta=0 -> req_ready[0]=1 in the same cycle; resp_valid at t+17 with resp_id=0 and cos/sin equal to a standalone `cordic` run for theta=0; busy=0 the cycle after the pop.
- All four requesters valid continuously with resp_ready=1:
  - grants rotate 0,1,2,3,0,... one per cycle.
  - resp_id sequence is 0,1,2,3,... from t+17 with no gaps.
- Fairness: req_valid=4'b1010 held → grants alternate 1,3,1,3; then req 0 rises while rr_ptr=2 → order 3,0,1.
- Backpressure, RESP_DEPTH=32, resp_ready=0, all requesters valid:
  - exactly 32 grants, then req_ready=0 while credits=32.
  - Raising resp_ready for 1 cycle pops 1 entry and permits exactly 1 new grant next cycle.
  - No FIFO overflow; tag_err stays 0.
- Reset mid-stream with 10 in flight and 5 buffered:
  - 1-cycle reset → resp_valid=0, busy=0, rr_ptr=0.
  - No stale responses appear in the following 20 cycles.
- Fault injection: force cor_valid_out=1 for one cycle with no issue → tag_err=1 and sticky, FIFO occupancy unchanged.
